// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider
// Description : Multi-cycle unsigned restoring divider. It divides a DW-bit
//               dividend by a VW-bit divisor and resolves one quotient bit
//               per clock. The typical use is to recover a multiplier operand
//               from its product.
//               Both the input side and the output side use a valid/ready
//               handshake. A new operand pair is accepted only in IDLE.
//               Divide-by-zero skips the iteration and reports directly.
// Ports       : clk, rst     - rising-edge clock, synchronous active-high reset
//               in_valid     - dividend/divisor presented
//               in_ready     - block can accept an operand pair (IDLE)
//               dividend     - DW-bit unsigned dividend
//               divisor      - VW-bit unsigned divisor
//               out_valid    - result available (DONE)
//               out_ready    - consumer accepts the result
//               quotient     - DW-bit unsigned quotient
//               remainder    - VW-bit unsigned remainder
//               div_by_zero  - result came from a zero divisor
// Options     : DIV_ROUND_EN - when defined, adds a ROUND state. That state
//               rounds the quotient to nearest and saturates it at all ones.
//               This adds one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int c_cnt_w = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(DW - 1);

`ifdef DIV_ROUND_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_DONE  = 2'd2,
        S_ROUND = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t              r_state;
    state_t              w_next_state;
    logic [DW-1:0]       r_q;
    logic [VW-1:0]       r_rem;
    logic [VW-1:0]       r_div;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_dbz;

    logic                w_div_zero;
    logic [VW:0]         w_shift;
    logic [VW:0]         w_trial;
    logic                w_fits;

    assign w_div_zero = (divisor == '0);

    // The partial remainder always stays below the divisor. For that reason,
    // only the VW+1-bit shifted value can exceed VW bits. Because the
    // subtraction is done at that width, its MSB is the borrow. In other
    // words, the MSB is set exactly when the shifted value is below the
    // divisor.
    assign w_shift = {r_rem, r_q[DW-1]};
    assign w_trial = w_shift - {1'b0, r_div};
    assign w_fits  = ~w_trial[VW];

`ifdef DIV_ROUND_EN
    logic                w_round_up;
    logic [DW-1:0]       w_q_inc;

    // Round half up: 2*rem >= divisor.
    assign w_round_up = ({r_rem, 1'b0} >= {1'b0, r_div});
    assign w_q_inc    = (&r_q) ? r_q : r_q + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = w_div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_last_step) begin
`ifdef DIV_ROUND_EN
                    w_next_state = S_ROUND;
`else
                    w_next_state = S_DONE;
`endif
                end
            end
`ifdef DIV_ROUND_EN
            S_ROUND: w_next_state = S_DONE;
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_rem <= '0;
            r_div <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_div <= divisor;
                        r_cnt <= '0;
                        if (w_div_zero) begin
                            r_q   <= '1;
                            r_rem <= dividend[VW-1:0];
                            r_dbz <= 1'b1;
                        end else begin
                            r_q   <= dividend;
                            r_rem <= '0;
                            r_dbz <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    // The dividend drains out of the top of r_q while the
                    // quotient bits enter at the bottom.
                    r_q   <= {r_q[DW-2:0], w_fits};
                    r_rem <= w_fits ? w_trial[VW-1:0] : w_shift[VW-1:0];
                    r_cnt <= r_cnt + 1'b1;
                end
`ifdef DIV_ROUND_EN
                S_ROUND: begin
                    if (w_round_up) begin
                        r_q   <= w_q_inc;
                        r_rem <= r_rem - r_div;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        r_dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign quotient    = r_q;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_restoring_divider
// Description : Directed self-checking bench for seq_restoring_divider with
//               default sizing (DW=8, VW=4). Expected values are computed by
//               hand. Separate expectations apply when DIV_ROUND_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

    localparam int DW = 8;
    localparam int VW = 4;
`ifdef DIV_ROUND_EN
    localparam int c_lat = DW + 1;
`else
    localparam int c_lat = DW;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one operand pair for one cycle. The task returns #1 after the
    // acceptance edge.
    task automatic start_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // The task counts clock edges after the acceptance edge until out_valid
    // is seen. The count is bounded by a cycle budget.
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid after ack"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after ack"}, 32'(in_ready), 32'd1);
        check({tag, " dbz after ack"}, 32'(div_by_zero), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                          input int eq, input int er, input int edbz, input int elat);
        int lat;
        start_op(a, b);
        wait_done(0, lat);
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
        check({tag, " in_ready in done"}, 32'(in_ready), 32'd0);
        finish_op(tag);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // out_ready has no effect while nothing is valid.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle out_ready in_ready", 32'(in_ready), 32'd1);
        check("idle out_ready out_valid", 32'(out_valid), 32'd0);

`ifdef DIV_ROUND_EN
        run_op("200/7", 8'd200, 4'd7, 29, 13, 0, c_lat);
`else
        run_op("200/7", 8'd200, 4'd7, 28, 4, 0, c_lat);
`endif
        run_op("255/15", 8'd255, 4'd15, 17, 0, 0, c_lat);
        run_op("0/9", 8'd0, 4'd9, 0, 0, 0, c_lat);
        run_op("5/0", 8'd5, 4'd0, 255, 5, 1, 0);

        // Hold the result in DONE while new operands are offered.
        start_op(8'd9, 4'd0);
        wait_done(0, lat);
        check("hold latency", 32'(lat), 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'd77;
        divisor  = 4'd3;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold in_ready", 32'(in_ready), 32'd0);
            check("hold quotient", 32'(quotient), 32'd255);
            check("hold remainder", 32'(remainder), 32'd9);
            check("hold div_by_zero", 32'(div_by_zero), 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold release in_ready", 32'(in_ready), 32'd1);
        check("hold release out_valid", 32'(out_valid), 32'd0);
        check("hold release dbz", 32'(div_by_zero), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold no stray accept", 32'(out_valid), 32'd0);

        // Toggle in_valid with junk operands during CALC.
        start_op(8'd123, 4'd10);
        repeat (4) begin
            @(negedge clk);
            in_valid = ~in_valid;
            dividend = 8'hFF;
            divisor  = 4'd0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_done(4, lat);
        check("toggle latency", 32'(lat), 32'(c_lat));
        check("toggle quotient", 32'(quotient), 32'd12);
        check("toggle remainder", 32'(remainder), 32'd3);
        check("toggle div_by_zero", 32'(div_by_zero), 32'd0);
        finish_op("toggle");

        // Reset during the fourth CALC cycle.
        start_op(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset quotient", 32'(quotient), 32'd0);
        check("midreset remainder", 32'(remainder), 32'd0);
        repeat (DW + 2) @(posedge clk);
        #1;
        check("midreset no output", 32'(out_valid), 32'd0);

        // Reset wins over a simultaneous in_valid.
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        dividend = 8'd9;
        divisor  = 4'd2;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst+valid in_ready", 32'(in_ready), 32'd1);
        check("rst+valid quotient", 32'(quotient), 32'd0);

        run_op("100/3", 8'd100, 4'd3, 33, 1, 0, c_lat);
        run_op("255/1", 8'd255, 4'd1, 255, 0, 0, c_lat);
        run_op("13/13", 8'd13, 4'd13, 1, 0, 0, c_lat);
`ifdef DIV_ROUND_EN
        run_op("14/4", 8'd14, 4'd4, 4, 14, 0, c_lat);
`else
        run_op("14/4", 8'd14, 4'd4, 3, 2, 0, c_lat);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
